// File: rtl/rv32i_types.sv
// Shared RV32I memory-access types: store/load size encoding, store FSM states, lane masks.
package rv32i_types;

   typedef enum logic [1:0] {
      st_word = 2'b00,
      st_byte = 2'b01,
      st_half = 2'b10,
      st_rsvd = 2'b11
   } store_type_t;

   typedef enum logic [1:0] {
      IDLE,
      BEAT0,
      BEAT1,
      FIN
   } store_state_t;

   localparam logic [3:0] BYTE_MASK = 4'b0001;
   localparam logic [3:0] HALF_MASK = 4'b0011;
   localparam logic [3:0] WORD_MASK = 4'b1111;

   // Reserved encoding yields an empty mask so it can never produce a split.
   function automatic logic [3:0] base_mask(input store_type_t t);
      case (t)
         st_byte: base_mask = BYTE_MASK;
         st_half: base_mask = HALF_MASK;
         st_word: base_mask = WORD_MASK;
         default: base_mask = 4'b0000;
      endcase
   endfunction

endpackage

// File: rtl/store_lane_gen.sv
// Combinational store lane generator: shifts the byte-enable mask and store data to the
// byte offset, producing a two-word view so a word-crossing store can be split into beats.
module store_lane_gen
   import rv32i_types::*;
(
   input  store_type_t store_type,
   input  logic [1:0]  off,
   input  logic [31:0] wdata,
   output logic [6:0]  full_mask,
   output logic [63:0] full_data,
   output logic        split
);

   assign full_mask = {3'b000, base_mask(store_type)} << off;
   assign full_data = {32'b0, wdata} << {off, 3'b000};
   assign split     = |full_mask[6:4];

endmodule

// File: rtl/store_align_unit.sv
// RV32I store alignment unit: drives the data-memory write port with lane-aligned beats.
// Build option STORE_SPLIT_EN: split word-crossing stores into two beats; otherwise reject them.
module store_align_unit
   import rv32i_types::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [1:0]  store_type,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] mem_address,
   output logic        mem_write,
   output logic [3:0]  mem_byte_enable,
   output logic [31:0] mem_wdata,
   input  logic        mem_resp,
   output logic        done,
   output logic        misaligned
);

   store_state_t state, state_d;
   store_type_t  req_type;
   logic [6:0]   full_mask;
   logic [63:0]  full_data;
   logic         split;
   logic [31:0]  mem_address_d;
   logic [3:0]   mem_byte_enable_d;
   logic [31:0]  mem_wdata_d;
   logic         mem_write_d;
   logic         misaligned_q, misaligned_d;
`ifdef STORE_SPLIT_EN
   logic [2:0]   hi_mask_q, hi_mask_d;
   logic [31:0]  hi_data_q, hi_data_d;
`else
   logic         unused_hi;
   assign unused_hi = ^{full_mask[6:4], full_data[63:32]};
`endif

   assign req_type = store_type_t'(store_type);

   store_lane_gen u_lane_gen (
      .store_type (req_type),
      .off        (addr[1:0]),
      .wdata      (wdata),
      .full_mask  (full_mask),
      .full_data  (full_data),
      .split      (split)
   );

   // NOTE: every signal gets a hold default before the case so no path infers a latch.
   always_comb begin
      state_d           = state;
      mem_address_d     = mem_address;
      mem_byte_enable_d = mem_byte_enable;
      mem_wdata_d       = mem_wdata;
      mem_write_d       = mem_write;
      misaligned_d      = misaligned_q;
`ifdef STORE_SPLIT_EN
      hi_mask_d         = hi_mask_q;
      hi_data_d         = hi_data_q;
`endif
      case (state)
         IDLE: begin
            if (req_valid) begin
               misaligned_d = 1'b0;
               if (req_type == st_rsvd) begin
                  state_d = FIN;
               end
`ifndef STORE_SPLIT_EN
               else if (split) begin
                  state_d      = FIN;
                  misaligned_d = 1'b1;
               end
`endif
               else begin
                  state_d           = BEAT0;
                  mem_write_d       = 1'b1;
                  mem_address_d     = {addr[31:2], 2'b00};
                  mem_byte_enable_d = full_mask[3:0];
                  mem_wdata_d       = full_data[31:0];
`ifdef STORE_SPLIT_EN
                  hi_mask_d         = full_mask[6:4];
                  hi_data_d         = full_data[63:32];
`endif
               end
            end
         end
         BEAT0: begin
            if (mem_resp) begin
`ifdef STORE_SPLIT_EN
               if (|hi_mask_q) begin
                  state_d           = BEAT1;
                  mem_address_d     = mem_address + 32'd4;
                  mem_byte_enable_d = {1'b0, hi_mask_q};
                  mem_wdata_d       = hi_data_q;
               end else
`endif
               begin
                  state_d     = FIN;
                  mem_write_d = 1'b0;
               end
            end
         end
`ifdef STORE_SPLIT_EN
         BEAT1: begin
            if (mem_resp) begin
               state_d     = FIN;
               mem_write_d = 1'b0;
            end
         end
`endif
         FIN:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= IDLE;
         mem_address     <= 32'b0;
         mem_byte_enable <= 4'b0;
         mem_wdata       <= 32'b0;
         mem_write       <= 1'b0;
         misaligned_q    <= 1'b0;
`ifdef STORE_SPLIT_EN
         hi_mask_q       <= 3'b0;
         hi_data_q       <= 32'b0;
`endif
      end else begin
         state           <= state_d;
         mem_address     <= mem_address_d;
         mem_byte_enable <= mem_byte_enable_d;
         mem_wdata       <= mem_wdata_d;
         mem_write       <= mem_write_d;
         misaligned_q    <= misaligned_d;
`ifdef STORE_SPLIT_EN
         hi_mask_q       <= hi_mask_d;
         hi_data_q       <= hi_data_d;
`endif
      end
   end

   assign req_ready  = (state == IDLE);
   assign done       = (state == FIN);
   assign misaligned = done & misaligned_q;

endmodule

// File: tb/tb_store_align_unit.sv
// Self-checking bench for store_align_unit: directed cases plus random stores against a
// byte-arithmetic reference model; follows the STORE_SPLIT_EN build option of the DUT.
module tb_store_align_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic [1:0]  store_type;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] mem_address;
   logic        mem_write;
   logic [3:0]  mem_byte_enable;
   logic [31:0] mem_wdata;
   logic        mem_resp;
   logic        done;
   logic        misaligned;

   int n_cmp = 0;
   int n_err = 0;

   int          exp_n;
   logic        exp_mis;
   logic [31:0] exp_addr [2];
   logic [31:0] exp_be   [2];
   logic [31:0] exp_data [2];

   store_align_unit dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .req_valid       (req_valid),
      .req_ready       (req_ready),
      .store_type      (store_type),
      .addr            (addr),
      .wdata           (wdata),
      .mem_address     (mem_address),
      .mem_write       (mem_write),
      .mem_byte_enable (mem_byte_enable),
      .mem_wdata       (mem_wdata),
      .mem_resp        (mem_resp),
      .done            (done),
      .misaligned      (misaligned)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference model: size in bytes, byte offset, and the data multiplied up to its lane.
   task automatic model(input logic [1:0] t, input logic [31:0] a, input logic [31:0] d);
      int          size;
      int          off;
      logic [63:0] v;
      logic [7:0]  m;
      logic [31:0] base;
      case (t)
         2'b00:   size = 4;
         2'b01:   size = 1;
         2'b10:   size = 2;
         default: size = 0;
      endcase
      off  = int'(a % 32'd4);
      base = a - 32'(off);
      v    = {32'b0, d} * (64'd1 << (8 * off));
      m    = 8'(((1 << size) - 1) << off);
      exp_mis = 1'b0;
      exp_n   = 0;
      if (size != 0) begin
         if (off + size > 4) begin
`ifdef STORE_SPLIT_EN
            exp_n = 2;
`else
            exp_mis = 1'b1;
`endif
         end else begin
            exp_n = 1;
         end
      end
      exp_addr[0] = base;
      exp_be[0]   = {28'b0, m[3:0]};
      exp_data[0] = v[31:0];
      exp_addr[1] = base + 32'd4;
      exp_be[1]   = {28'b0, m[7:4]};
      exp_data[1] = v[63:32];
   endtask

   // Garbage on the request inputs while busy must be ignored.
   task automatic drive_noise();
      req_valid  = 1'($urandom_range(0, 1));
      store_type = 2'($urandom_range(0, 3));
      addr       = $urandom;
      wdata      = $urandom;
   endtask

   // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
   task automatic run_store(input logic [1:0] t, input logic [31:0] a, input logic [31:0] d,
                            input int dly0, input int dly1);
      int dly;
      model(t, a, d);
      check("req_ready_before", {31'b0, req_ready}, 32'd1);
      req_valid  = 1'b1;
      store_type = t;
      addr       = a;
      wdata      = d;
      mem_resp   = 1'($urandom_range(0, 1));
      @(negedge clk);
      for (int b = 0; b < exp_n; b++) begin
         dly = (b == 0) ? dly0 : dly1;
         for (int w = 0; w <= dly; w++) begin
            drive_noise();
            mem_resp = (w == dly);
            check("beat_mem_write", {31'b0, mem_write}, 32'd1);
            check("beat_address", mem_address, exp_addr[b]);
            check("beat_byte_enable", {28'b0, mem_byte_enable}, exp_be[b]);
            check("beat_wdata", mem_wdata, exp_data[b]);
            check("beat_done", {31'b0, done}, 32'd0);
            check("beat_req_ready", {31'b0, req_ready}, 32'd0);
            @(negedge clk);
         end
      end
      drive_noise();
      mem_resp = 1'($urandom_range(0, 1));
      check("fin_done", {31'b0, done}, 32'd1);
      check("fin_misaligned", {31'b0, misaligned}, {31'b0, exp_mis});
      check("fin_mem_write", {31'b0, mem_write}, 32'd0);
      check("fin_req_ready", {31'b0, req_ready}, 32'd0);
      @(negedge clk);
      req_valid = 1'b0;
      mem_resp  = 1'b0;
      check("post_done", {31'b0, done}, 32'd0);
      check("post_req_ready", {31'b0, req_ready}, 32'd1);
   endtask

   initial begin
      logic [31:0] rst_addr;
      rst_n      = 1'b0;
      req_valid  = 1'b0;
      store_type = 2'b00;
      addr       = 32'b0;
      wdata      = 32'b0;
      mem_resp   = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_mem_write", {31'b0, mem_write}, 32'd0);
      check("rst_mem_address", mem_address, 32'd0);
      check("rst_byte_enable", {28'b0, mem_byte_enable}, 32'd0);
      check("rst_mem_wdata", mem_wdata, 32'd0);
      check("rst_done", {31'b0, done}, 32'd0);
      check("rst_misaligned", {31'b0, misaligned}, 32'd0);
      check("rst_req_ready", {31'b0, req_ready}, 32'd1);
      rst_n = 1'b1;
      @(negedge clk);

      run_store(2'b00, 32'h0000_1000, 32'hDEAD_BEEF, 0, 0);
      run_store(2'b01, 32'h0000_1003, 32'hAABB_CCDD, 0, 0);
      run_store(2'b10, 32'h0000_2001, 32'h1234_ABCD, 3, 0);
      run_store(2'b00, 32'h0000_3002, 32'h1122_3344, 0, 0);
      run_store(2'b00, 32'h0000_3002, 32'h1122_3344, 2, 1);
      run_store(2'b11, 32'h0000_5000, 32'hCAFE_F00D, 0, 0);
      run_store(2'b10, 32'h0000_0003, 32'hFFFF_8001, 1, 2);

      // Reset in the middle of a beat abandons the store.
`ifdef STORE_SPLIT_EN
      rst_addr = 32'h0000_40FF;
`else
      rst_addr = 32'h0000_40FE;
`endif
      req_valid  = 1'b1;
      store_type = 2'b10;
      addr       = rst_addr;
      wdata      = 32'h0000_BEEF;
      @(negedge clk);
      req_valid = 1'b0;
      check("rstmid_write_before", {31'b0, mem_write}, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("rstmid_write_async", {31'b0, mem_write}, 32'd0);
      check("rstmid_done", {31'b0, done}, 32'd0);
      @(negedge clk);
      rst_n    = 1'b1;
      mem_resp = 1'b1;
      check("rstmid_req_ready", {31'b0, req_ready}, 32'd1);
      repeat (2) begin
         @(negedge clk);
         check("rstmid_no_done", {31'b0, done}, 32'd0);
         check("rstmid_no_write", {31'b0, mem_write}, 32'd0);
      end
      mem_resp = 1'b0;
      run_store(2'b01, 32'h0000_4101, 32'h0000_005A, 0, 0);

      for (int i = 0; i < 60; i++) begin
         run_store(2'($urandom_range(0, 3)), $urandom, $urandom,
                   $urandom_range(0, 3), $urandom_range(0, 3));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/store_align_unit.md
Name: store_align_unit

Overview:
- Store-side counterpart of the load lane-extraction logic. Takes an RV32I store (SB/SH/SW, byte address, register data) and produces the write-data lanes and byte-enable mask.
- Drives the data-memory write interface and handles the mem_resp handshake.
- Splits stores that cross a word boundary into two word-aligned beats.
- Sits between the MEM-stage control and the data-memory/cache port.

Parameters:
- none; widths are fixed at rv32i_word (32) and a 4-bit byte-enable.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  store request present
- req_ready  out  1  unit can accept a request
- store_type  in  2  00=word, 01=byte, 10=half, 11=reserved (same encoding as the load path)
- addr  in  32  byte address of the store
- wdata  in  32  register data; low byte/half/word is stored
- mem_address  out  32  word-aligned memory address
- mem_write  out  1  write strobe, held until mem_resp
- mem_byte_enable  out  4  lane mask, bit i enables mem_wdata[8i+7:8i]
- mem_wdata  out  32  lane-aligned write data
- mem_resp  in  1  memory completed the current beat
- done  out  1  one-cycle pulse when the store has fully retired
- misaligned  out  1  valid with done; 1 = request rejected as misaligned

Behaviour:
- Reset (asynchronous, active-low):
  - State goes to IDLE.
  - mem_write, done, misaligned = 0; mem_address, mem_byte_enable, mem_wdata = 0; req_ready = 1.
  - Asserting reset mid-beat drops mem_write immediately and the store is abandoned.
- Handshake:
  - req_ready = 1 only in IDLE.
  - Accept on req_valid && req_ready; addr, store_type and wdata are registered at acceptance.
  - Inputs are ignored outside IDLE.
- Alignment, with off = addr[1:0]:
  - base mask: 0001 for byte, 0011 for half, 1111 for word.
  - full mask = base << off (7 bits); full data = {32'b0, wdata} << (8*off) (64 bits).
  - Beat0: address {addr[31:2],2'b00}, enables full_mask[3:0], data full_data[31:0].
  - Beat1: address beat0 + 4, enables full_mask[6:4], data full_data[63:32].
  - split = |full_mask[6:4].
- States:
  - IDLE: on accept go to BEAT0, or to FIN for a reserved type.
  - BEAT0: mem_write = 1 with beat0 outputs. On mem_resp go to BEAT1 if split, else FIN.
  - BEAT1: mem_write = 1 with beat1 outputs. On mem_resp go to FIN.
  - FIN: done = 1 for one cycle, mem_write = 0, then IDLE. req_ready rises the cycle after done.
- Latency: with zero-wait memory (mem_resp in the first cycle of the beat), done follows acceptance by 2 cycles for an aligned store and 3 for a split store. Each cycle mem_resp is late adds one cycle.
- Strobe rules:
  - mem_write never de-asserts between the start of a beat and its mem_resp.
  - mem_address, mem_byte_enable and mem_wdata are stable for the whole beat.
  - mem_resp seen outside BEAT0/BEAT1 is ignored.
- Reserved type 11: no memory access; done pulses with misaligned = 0.
- No request queuing: a back-to-back req_valid is accepted on the first IDLE cycle.

Optional Feature:
- Macro STORE_SPLIT_EN.
- Defined: boundary-crossing stores are split into two beats as described above; misaligned is always 0.
- Undefined: if split would be 1, the unit issues no memory access, goes IDLE to FIN, and pulses done with misaligned = 1 (for the trap path). The BEAT1 state and the beat1 datapath are not compiled.

Decomposition:
- rv32i_types package holds:
  - store_type_t enum {st_word = 2'b00, st_byte = 2'b01, st_half = 2'b10, st_rsvd = 2'b11}, shared with the load path.
  - store_state_t enum {IDLE, BEAT0, BEAT1, FIN}.
  - Constants BYTE_MASK = 4'b0001, HALF_MASK = 4'b0011, WORD_MASK = 4'b1111.
- One combinational sub-module, store_lane_gen:
  - Inputs: store_type, off, wdata.
  - Outputs: full_mask[6:0], full_data[63:0], split.
  - Separately unit-testable.
- The FSM and output registers stay in store_align_unit.

Test Plan:
- SW at 0x1000, data 0xDEADBEEF, zero-wait memory -> one beat: address 0x1000, enables 1111, data 0xDEADBEEF; done 2 cycles after acceptance.
- SB at 0x1003, data 0xAABBCCDD -> address 0x1000, enables 1000, data 0xDD000000; a single beat.
- SH at 0x2001, data 0x1234ABCD, mem_resp delayed 3 cycles -> enables 0110, data 0x34ABCD00; mem_write and outputs held stable for 4 cycles; done 1 cycle after mem_resp.
- SW at 0x3002, data 0x11223344, STORE_SPLIT_EN defined -> beat0: 0x3000, enables 1100, data 0x33440000; beat1: 0x3004, enables 0011, data 0x00001122; done after the second mem_resp. Without the macro -> no mem_write, done with misaligned = 1.
- SH at 0x40FF, data 0x0000BEEF, rst_n pulsed low during BEAT0 -> mem_write drops asynchronously; after release req_ready = 1, done is never asserted, and a new SB then completes normally.
- store_type 11 -> no mem_write; done pulses 1 cycle after acceptance with misaligned = 0.
